ord_sram_port: RTL and testbench
================================

Name: ord_sram_port

Overview:
Initiator-side adapter that drives the ordinary SRAM word port (req/we/addr/wdata/be, read data one cycle after request) on behalf of a load/store client. Accepts byte-addressed, sized requests over valid/ready and generates word address, byte enables and lane-shifted write data. Aligns and sign/zero-extends read data and returns every request as a response over valid/ready. Propagates the two independent taint flags (t0, t1) on every data path so the block composes with the 2-flag IFT SRAM model.

Parameters:
DATA_WIDTH, 64, SRAM word width in bits
NUM_BYTES, 8, byte lanes per word
ADDR_WIDTH, 16, SRAM word-address width
VLEN, 64, PC width, equal to riscv::VLEN

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
req_valid_i  in  1  client request valid
req_ready_o  out  1  request accepted when valid&ready
req_we_i  in  1  1=store, 0=load
req_addr_i  in  ADDR_WIDTH+3  byte address
req_size_i  in  2  0=B,1=H,2=W,3=D
req_signed_i  in  1  sign-extend load result
req_wdata_i  in  DATA_WIDTH  store data, LSB-aligned
req_pc_i  in  VLEN  PC of the issuing instruction
req_addr_t0_i/req_addr_t1_i  in  ADDR_WIDTH+3  address taint
req_wdata_t0_i/req_wdata_t1_i  in  DATA_WIDTH  store-data taint
resp_valid_o  out  1  response valid
resp_ready_i  in  1  client accepts response
resp_rdata_o  out  DATA_WIDTH  extended load data; 0 for stores
resp_err_o  out  1  misaligned request; no SRAM access made
resp_rdata_t0_o/resp_rdata_t1_o  out  DATA_WIDTH  result taint
sram_req_o, sram_we_o  out  1  SRAM request, write enable
sram_addr_o  out  ADDR_WIDTH  word address
sram_wdata_o  out  DATA_WIDTH  lane-shifted write data
sram_be_o  out  NUM_BYTES  byte enables
sram_pc_o  out  VLEN  registered req_pc_i
sram_addr_t0_o/t1_o  out  ADDR_WIDTH;  sram_wdata_t0_o/t1_o  out  DATA_WIDTH;  sram_rdata_t0_i/t1_i  in  DATA_WIDTH  taint shadows
sram_rdata_i  in  DATA_WIDTH  read data, valid the cycle after sram_req_o&!sram_we_o

Behaviour:
- FSM: IDLE, ISSUE, CAPTURE, RESP. req_ready_o=1 only in IDLE; one request in flight at a time.
- IDLE, accept at cycle T: misaligned (addr mod 2^size != 0) -> RESP at T+1 with err=1, rdata=0, no sram_req_o. Otherwise register SRAM fields -> ISSUE.
- ISSUE (T+1): sram_req_o=1 for exactly one cycle. Store -> RESP at T+2. Load -> CAPTURE.
- CAPTURE (T+2): sample sram_rdata_i and taint, then shift right by 8*off and extend by size/signed -> RESP at T+3.
- RESP: resp_valid_o=1. Data, err and taint stay stable until resp_ready_i; then go to IDLE. The next request can be accepted the cycle after.
- Field rules: off=addr[2:0]; sram_addr_o=addr[ADDR_WIDTH+2:3]; be=((1<<(1<<size))-1)<<off; wdata=req_wdata<<(8*off). Outside ISSUE: sram_req_o=0 and sram_we_o=0; other SRAM outputs keep their registered values.
- Taint, per flag independently:
  - sram_addr_t = addr_t word bits; wdata_t shifted exactly like wdata.
  - Load result taint is shifted/extended like data; signed extension replicates the sign-bit taint.
  - Any taint on addr[2:0] forces the full-width result taint to ones.
  - Error response taint = replicate(|addr_t).
  - Store response taint = 0.
- Reset asserted (any state, including mid-transaction): immediately state=IDLE, all registered outputs 0, resp_valid_o=0, sram_req_o=0. An in-flight SRAM read is discarded and produces no response.

Decomposition:
- Package ord_sram_port_pkg: size enum (SZ_B/H/W/D), FSM state enum, OFF_W=$clog2(NUM_BYTES).
- One sub-module, ord_sram_port_align: combinational load shift + extend for data and both taint flags, instanced three times.

Test Plan:
- SD to 0x40, data 0x1122334455667788 -> sram_req_o at T+1 with addr=0x8, be=0xFF, we=1; resp_valid_o at T+2, err=0.
- SB to 0x43, data 0xAB -> be=0x08, sram_wdata_o=0x00000000AB000000. Then LBU 0x43 -> resp_rdata_o=0xAB at T+3.
- LB signed 0x43, sram_rdata_i=0x0000000080000000 -> resp_rdata_o=0xFFFFFFFFFFFFFF80. LB unsigned -> 0x80.
- LW to 0x42 -> err=1, rdata=0, sram_req_o never asserted, resp at T+1.
- LD 0x40 with req_addr_t0_i=0x002 -> resp_rdata_t0_o=all ones, resp_rdata_t1_o=0. LH 0x40 with sram_rdata_t1_i=0x0000000000000100 -> resp_rdata_t1_o=0x100.
- Hold resp_ready_i=0 for 5 cycles -> response stable, req_ready_o=0. Assert rst_i during ISSUE -> next cycle IDLE, no response, sram_req_o=0.

Source files
------------

// File: rtl/ord_sram_port_pkg.sv
// Shared types and constants for the ordinary SRAM word-port adapter.
package ord_sram_port_pkg;

    localparam int unsigned NUM_BYTES_DEF = 8;
    localparam int unsigned OFF_W         = $clog2(NUM_BYTES_DEF);

    // Access size, encoded as log2 of the byte count
    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StIssue   = 2'd1,
        StCapture = 2'd2,
        StResp    = 2'd3
    } state_e;

endpackage

// File: rtl/ord_sram_port_if.sv
// Client-side request/response bus of the SRAM port adapter, with two-flag taint shadows.
interface ord_sram_port_if #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned VLEN       = 64
);
    import ord_sram_port_pkg::*;

    logic                    req_valid;
    logic                    req_ready;
    logic                    req_we;
    logic [ADDR_WIDTH+2:0]   req_addr;
    size_e                   req_size;
    logic                    req_signed;
    logic [DATA_WIDTH-1:0]   req_wdata;
    logic [VLEN-1:0]         req_pc;
    logic [ADDR_WIDTH+2:0]   req_addr_t0;
    logic [ADDR_WIDTH+2:0]   req_addr_t1;
    logic [DATA_WIDTH-1:0]   req_wdata_t0;
    logic [DATA_WIDTH-1:0]   req_wdata_t1;

    logic                    resp_valid;
    logic                    resp_ready;
    logic [DATA_WIDTH-1:0]   resp_rdata;
    logic                    resp_err;
    logic [DATA_WIDTH-1:0]   resp_rdata_t0;
    logic [DATA_WIDTH-1:0]   resp_rdata_t1;

    // Load/store client
    modport master (
        output req_valid, req_we, req_addr, req_size, req_signed, req_wdata, req_pc,
               req_addr_t0, req_addr_t1, req_wdata_t0, req_wdata_t1, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err, resp_rdata_t0, resp_rdata_t1
    );

    // Adapter
    modport slave (
        input  req_valid, req_we, req_addr, req_size, req_signed, req_wdata, req_pc,
               req_addr_t0, req_addr_t1, req_wdata_t0, req_wdata_t1, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err, resp_rdata_t0, resp_rdata_t1
    );

endinterface

// File: rtl/ord_sram_port_align.sv
// Load alignment: shift a word right to the addressed lane and extend it to full width.
// Applied identically to data and taint so the sign-bit taint is what gets replicated.
module ord_sram_port_align
    import ord_sram_port_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64
) (
    input  logic [DATA_WIDTH-1:0] i_word,
    input  logic [OFF_W-1:0]      i_off,
    input  size_e                 i_size,
    input  logic                  i_signed,
    output logic [DATA_WIDTH-1:0] o_word
);

    logic [DATA_WIDTH-1:0] w_shift;

    assign w_shift = i_word >> {i_off, 3'b000};

    // Extend the low 2^size bytes of the shifted word
    always_comb begin
        o_word = w_shift;
        unique case (i_size)
            SZ_B: o_word = {{(DATA_WIDTH-8){i_signed & w_shift[7]}},   w_shift[7:0]};
            SZ_H: o_word = {{(DATA_WIDTH-16){i_signed & w_shift[15]}}, w_shift[15:0]};
            SZ_W: o_word = {{(DATA_WIDTH-32){i_signed & w_shift[31]}}, w_shift[31:0]};
            SZ_D: o_word = w_shift;
            default: o_word = w_shift;
        endcase
    end

endmodule

// File: rtl/ord_sram_port.sv
// Initiator adapter from a sized, byte-addressed load/store client to the SRAM word port.
// One request in flight; loads return one cycle after the SRAM request.
module ord_sram_port
    import ord_sram_port_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned NUM_BYTES  = 8,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned VLEN       = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    ord_sram_port_if.slave        bus,
    output logic                  sram_req_o,
    output logic                  sram_we_o,
    output logic [ADDR_WIDTH-1:0] sram_addr_o,
    output logic [DATA_WIDTH-1:0] sram_wdata_o,
    output logic [NUM_BYTES-1:0]  sram_be_o,
    output logic [VLEN-1:0]       sram_pc_o,
    output logic [ADDR_WIDTH-1:0] sram_addr_t0_o,
    output logic [ADDR_WIDTH-1:0] sram_addr_t1_o,
    output logic [DATA_WIDTH-1:0] sram_wdata_t0_o,
    output logic [DATA_WIDTH-1:0] sram_wdata_t1_o,
    input  logic [DATA_WIDTH-1:0] sram_rdata_i,
    input  logic [DATA_WIDTH-1:0] sram_rdata_t0_i,
    input  logic [DATA_WIDTH-1:0] sram_rdata_t1_i
);

    state_e                r_state, w_state_next;
    logic                  r_we, r_signed, r_off_t0, r_off_t1;
    size_e                 r_size;
    logic [OFF_W-1:0]      r_off;
    logic [ADDR_WIDTH-1:0] r_addr, r_addr_t0, r_addr_t1;
    logic [DATA_WIDTH-1:0] r_wdata, r_wdata_t0, r_wdata_t1;
    logic [NUM_BYTES-1:0]  r_be;
    logic [VLEN-1:0]       r_pc;
    logic                  r_resp_err;
    logic [DATA_WIDTH-1:0] r_resp_rdata, r_resp_t0, r_resp_t1;

    logic                  w_req_ready, w_resp_valid, w_sram_req, w_sram_we;
    logic                  w_accept, w_misalign;
    logic [OFF_W-1:0]      w_off;
    logic [NUM_BYTES-1:0]  w_be_base;
    logic [DATA_WIDTH-1:0] w_ld_data, w_ld_t0, w_ld_t1;

    assign w_off     = bus.req_addr[OFF_W-1:0];
    assign w_accept  = bus.req_valid & w_req_ready;
    assign w_be_base = NUM_BYTES'((1 << (1 << bus.req_size)) - 1);

    // Natural alignment: the low size bits of the byte address must be zero
    always_comb begin
        w_misalign = 1'b0;
        unique case (bus.req_size)
            SZ_B: w_misalign = 1'b0;
            SZ_H: w_misalign = w_off[0];
            SZ_W: w_misalign = |w_off[1:0];
            SZ_D: w_misalign = |w_off;
            default: w_misalign = 1'b0;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= StIdle;
        else       r_state <= w_state_next;
    end

    // FSM next state and handshake/strobe outputs
    always_comb begin
        w_state_next = r_state;
        w_req_ready  = 1'b0;
        w_resp_valid = 1'b0;
        w_sram_req   = 1'b0;
        w_sram_we    = 1'b0;
        unique case (r_state)
            StIdle: begin
                w_req_ready = 1'b1;
                if (bus.req_valid) w_state_next = w_misalign ? StResp : StIssue;
            end
            StIssue: begin
                w_sram_req   = 1'b1;
                w_sram_we    = r_we;
                w_state_next = r_we ? StResp : StCapture;
            end
            StCapture: w_state_next = StResp;
            StResp: begin
                w_resp_valid = 1'b1;
                if (bus.resp_ready) w_state_next = StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

    ord_sram_port_align #(.DATA_WIDTH(DATA_WIDTH)) u_align_data (
        .i_word(sram_rdata_i), .i_off(r_off), .i_size(r_size), .i_signed(r_signed),
        .o_word(w_ld_data)
    );
    ord_sram_port_align #(.DATA_WIDTH(DATA_WIDTH)) u_align_t0 (
        .i_word(sram_rdata_t0_i), .i_off(r_off), .i_size(r_size), .i_signed(r_signed),
        .o_word(w_ld_t0)
    );
    ord_sram_port_align #(.DATA_WIDTH(DATA_WIDTH)) u_align_t1 (
        .i_word(sram_rdata_t1_i), .i_off(r_off), .i_size(r_size), .i_signed(r_signed),
        .o_word(w_ld_t1)
    );

    // Request fields are captured on accept; response is built on error, store issue or capture
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_we         <= 1'b0;
            r_signed     <= 1'b0;
            r_size       <= SZ_B;
            r_off        <= '0;
            r_off_t0     <= 1'b0;
            r_off_t1     <= 1'b0;
            r_addr       <= '0;
            r_addr_t0    <= '0;
            r_addr_t1    <= '0;
            r_wdata      <= '0;
            r_wdata_t0   <= '0;
            r_wdata_t1   <= '0;
            r_be         <= '0;
            r_pc         <= '0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_t0    <= '0;
            r_resp_t1    <= '0;
        end else begin
            if (w_accept && !w_misalign) begin
                r_we       <= bus.req_we;
                r_signed   <= bus.req_signed;
                r_size     <= bus.req_size;
                r_off      <= w_off;
                r_off_t0   <= |bus.req_addr_t0[OFF_W-1:0];
                r_off_t1   <= |bus.req_addr_t1[OFF_W-1:0];
                r_addr     <= bus.req_addr[ADDR_WIDTH+OFF_W-1:OFF_W];
                r_addr_t0  <= bus.req_addr_t0[ADDR_WIDTH+OFF_W-1:OFF_W];
                r_addr_t1  <= bus.req_addr_t1[ADDR_WIDTH+OFF_W-1:OFF_W];
                r_wdata    <= bus.req_wdata << {w_off, 3'b000};
                r_wdata_t0 <= bus.req_wdata_t0 << {w_off, 3'b000};
                r_wdata_t1 <= bus.req_wdata_t1 << {w_off, 3'b000};
                r_be       <= w_be_base << w_off;
                r_pc       <= bus.req_pc;
            end
            if (w_accept && w_misalign) begin
                r_resp_err   <= 1'b1;
                r_resp_rdata <= '0;
                r_resp_t0    <= {DATA_WIDTH{|bus.req_addr_t0}};
                r_resp_t1    <= {DATA_WIDTH{|bus.req_addr_t1}};
            end
            if (r_state == StIssue && r_we) begin
                r_resp_err   <= 1'b0;
                r_resp_rdata <= '0;
                r_resp_t0    <= '0;
                r_resp_t1    <= '0;
            end
            if (r_state == StCapture) begin
                r_resp_err   <= 1'b0;
                r_resp_rdata <= w_ld_data;
                // A tainted byte offset taints which lanes were selected, hence the whole result
                r_resp_t0    <= r_off_t0 ? '1 : w_ld_t0;
                r_resp_t1    <= r_off_t1 ? '1 : w_ld_t1;
            end
        end
    end

    assign bus.req_ready     = w_req_ready;
    assign bus.resp_valid    = w_resp_valid;
    assign bus.resp_err      = r_resp_err;
    assign bus.resp_rdata    = r_resp_rdata;
    assign bus.resp_rdata_t0 = r_resp_t0;
    assign bus.resp_rdata_t1 = r_resp_t1;

    assign sram_req_o      = w_sram_req;
    assign sram_we_o       = w_sram_we;
    assign sram_addr_o     = r_addr;
    assign sram_wdata_o    = r_wdata;
    assign sram_be_o       = r_be;
    assign sram_pc_o       = r_pc;
    assign sram_addr_t0_o  = r_addr_t0;
    assign sram_addr_t1_o  = r_addr_t1;
    assign sram_wdata_t0_o = r_wdata_t0;
    assign sram_wdata_t1_o = r_wdata_t1;

endmodule

// File: tb/tb_ord_sram_port.sv
// Directed vector bench for ord_sram_port: request fields, latency, alignment, taint, backpressure
// and mid-transaction reset.
module tb_ord_sram_port;
    import ord_sram_port_pkg::*;

    localparam int unsigned DW = 64;
    localparam int unsigned AW = 16;
    localparam logic [63:0] JUNK = 64'hDEAD_BEEF_DEAD_BEEF;

    typedef struct {
        logic        we;
        logic [18:0] addr;
        logic [1:0]  size;
        logic        sgn;
        logic [63:0] wdata, wdata_t0, wdata_t1;
        logic [18:0] addr_t0, addr_t1;
        logic [63:0] pc;
        logic [63:0] rdata, rdata_t0, rdata_t1;
        int          exp_req_cyc, exp_resp_cyc;
        logic [7:0]  exp_be;
        logic [15:0] exp_saddr, exp_saddr_t0, exp_saddr_t1;
        logic [63:0] exp_swdata, exp_swdata_t0, exp_swdata_t1;
        logic        exp_err;
        logic [63:0] exp_rdata, exp_t0, exp_t1;
    } vec_t;

    logic          clk, rst;
    logic          sram_req, sram_we;
    logic [AW-1:0] sram_addr, sram_addr_t0, sram_addr_t1;
    logic [DW-1:0] sram_wdata, sram_wdata_t0, sram_wdata_t1;
    logic [7:0]    sram_be;
    logic [63:0]   sram_pc;
    logic [DW-1:0] sram_rdata, sram_rdata_t0, sram_rdata_t1;

    int n_chk = 0;
    int n_err = 0;
    vec_t vecs[$];

    ord_sram_port_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .VLEN(64)) bus ();

    ord_sram_port #(.DATA_WIDTH(DW), .NUM_BYTES(8), .ADDR_WIDTH(AW), .VLEN(64)) dut (
        .clk_i(clk), .rst_i(rst), .bus(bus),
        .sram_req_o(sram_req), .sram_we_o(sram_we), .sram_addr_o(sram_addr),
        .sram_wdata_o(sram_wdata), .sram_be_o(sram_be), .sram_pc_o(sram_pc),
        .sram_addr_t0_o(sram_addr_t0), .sram_addr_t1_o(sram_addr_t1),
        .sram_wdata_t0_o(sram_wdata_t0), .sram_wdata_t1_o(sram_wdata_t1),
        .sram_rdata_i(sram_rdata), .sram_rdata_t0_i(sram_rdata_t0),
        .sram_rdata_t1_i(sram_rdata_t1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "bench timed out");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic drive_req(input vec_t v);
        bus.req_we       = v.we;
        bus.req_addr     = v.addr;
        bus.req_size     = size_e'(v.size);
        bus.req_signed   = v.sgn;
        bus.req_wdata    = v.wdata;
        bus.req_pc       = v.pc;
        bus.req_addr_t0  = v.addr_t0;
        bus.req_addr_t1  = v.addr_t1;
        bus.req_wdata_t0 = v.wdata_t0;
        bus.req_wdata_t1 = v.wdata_t1;
        bus.req_valid    = 1'b1;
    endtask

    // One transaction; cycle c is the c-th clock after the accepting edge
    task automatic run_vec(input vec_t v, input int idx);
        int req_cyc = 0;
        int resp_cyc = 0;
        int n_req = 0;
        bit pend = 0;
        string p;
        p = $sformatf("v%0d", idx);
        @(negedge clk);
        chk({p, "_req_ready"}, 64'(bus.req_ready), 64'd1);
        drive_req(v);
        bus.resp_ready = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 8 && resp_cyc == 0; c++) begin
            @(negedge clk);
            bus.req_valid = 1'b0;
            // Read data is only valid in the cycle after the SRAM request
            if (pend) begin
                sram_rdata = v.rdata; sram_rdata_t0 = v.rdata_t0; sram_rdata_t1 = v.rdata_t1;
                pend = 0;
            end else begin
                sram_rdata = JUNK; sram_rdata_t0 = JUNK; sram_rdata_t1 = JUNK;
            end
            if (sram_req) begin
                n_req++;
                if (req_cyc == 0) req_cyc = c;
                chk({p, "_we"}, 64'(sram_we), 64'(v.we));
                chk({p, "_saddr"}, 64'(sram_addr), 64'(v.exp_saddr));
                chk({p, "_be"}, 64'(sram_be), 64'(v.exp_be));
                chk({p, "_pc"}, sram_pc, v.pc);
                chk({p, "_saddr_t0"}, 64'(sram_addr_t0), 64'(v.exp_saddr_t0));
                chk({p, "_saddr_t1"}, 64'(sram_addr_t1), 64'(v.exp_saddr_t1));
                if (v.we) begin
                    chk({p, "_swdata"}, sram_wdata, v.exp_swdata);
                    chk({p, "_swdata_t0"}, sram_wdata_t0, v.exp_swdata_t0);
                    chk({p, "_swdata_t1"}, sram_wdata_t1, v.exp_swdata_t1);
                end else begin
                    pend = 1;
                end
            end
            if (bus.resp_valid) begin
                resp_cyc = c;
                chk({p, "_err"}, 64'(bus.resp_err), 64'(v.exp_err));
                chk({p, "_rdata"}, bus.resp_rdata, v.exp_rdata);
                chk({p, "_rdata_t0"}, bus.resp_rdata_t0, v.exp_t0);
                chk({p, "_rdata_t1"}, bus.resp_rdata_t1, v.exp_t1);
                chk({p, "_we_in_resp"}, 64'(sram_we), 64'd0);
            end
        end
        chk({p, "_req_cycle"}, 64'(req_cyc), 64'(v.exp_req_cyc));
        chk({p, "_req_count"}, 64'(n_req), 64'(v.exp_req_cyc != 0 ? 1 : 0));
        chk({p, "_resp_cycle"}, 64'(resp_cyc), 64'(v.exp_resp_cyc));
    endtask

    task automatic add_store(input logic [18:0] a, input logic [1:0] sz, input logic [63:0] wd,
                             input logic [7:0] be, input logic [63:0] swd);
        vec_t v;
        v = '{default: '0};
        v.we = 1'b1; v.addr = a; v.size = sz; v.wdata = wd; v.pc = 64'h8000_0000 + 64'(a);
        v.exp_req_cyc = 1; v.exp_resp_cyc = 2; v.exp_be = be; v.exp_saddr = a[18:3];
        v.exp_swdata = swd;
        vecs.push_back(v);
    endtask

    task automatic add_load(input logic [18:0] a, input logic [1:0] sz, input logic sg,
                            input logic [63:0] rd, input logic [7:0] be, input logic [63:0] erd);
        vec_t v;
        v = '{default: '0};
        v.addr = a; v.size = sz; v.sgn = sg; v.rdata = rd; v.pc = 64'h4000_0000 + 64'(a);
        v.exp_req_cyc = 1; v.exp_resp_cyc = 3; v.exp_be = be; v.exp_saddr = a[18:3];
        v.exp_rdata = erd;
        vecs.push_back(v);
    endtask

    task automatic add_misalign(input logic [18:0] a, input logic [1:0] sz,
                                input logic [18:0] at0, input logic [18:0] at1,
                                input logic [63:0] et0, input logic [63:0] et1);
        vec_t v;
        v = '{default: '0};
        v.addr = a; v.size = sz; v.addr_t0 = at0; v.addr_t1 = at1;
        v.exp_req_cyc = 0; v.exp_resp_cyc = 1; v.exp_err = 1'b1; v.exp_t0 = et0; v.exp_t1 = et1;
        vecs.push_back(v);
    endtask

    initial begin
        int found;
        int bad;
        vec_t v;
        rst = 1'b1;
        bus.req_valid = 1'b0; bus.resp_ready = 1'b1;
        bus.req_we = 1'b0; bus.req_addr = '0; bus.req_size = SZ_B; bus.req_signed = 1'b0;
        bus.req_wdata = '0; bus.req_pc = '0; bus.req_addr_t0 = '0; bus.req_addr_t1 = '0;
        bus.req_wdata_t0 = '0; bus.req_wdata_t1 = '0;
        sram_rdata = JUNK; sram_rdata_t0 = JUNK; sram_rdata_t1 = JUNK;

        // 0: SD 0x40
        add_store(19'h40, 2'd3, 64'h1122_3344_5566_7788, 8'hFF, 64'h1122_3344_5566_7788);
        // 1: SB 0x43 with data taint on the low nibble
        add_store(19'h43, 2'd0, 64'hAB, 8'h08, 64'h0000_0000_AB00_0000);
        vecs[1].wdata_t0 = 64'h0F; vecs[1].exp_swdata_t0 = 64'h0000_0000_0F00_0000;
        // 2: LBU 0x43, data taint on the selected byte
        add_load(19'h43, 2'd0, 1'b0, 64'h0000_0000_AB00_0000, 8'h08, 64'hAB);
        vecs[2].rdata_t0 = 64'h0000_0000_0100_0000; vecs[2].exp_t0 = 64'h1;
        // 3: LB signed 0x43
        add_load(19'h43, 2'd0, 1'b1, 64'h0000_0000_8000_0000, 8'h08, 64'hFFFF_FFFF_FFFF_FF80);
        // 4: LB unsigned 0x43, taint above the byte is dropped
        add_load(19'h43, 2'd0, 1'b0, 64'h0000_0000_8000_0000, 8'h08, 64'h80);
        vecs[4].rdata_t1 = 64'hFFFF_FFFF_0000_0000;
        // 5: LW 0x42 misaligned
        add_misalign(19'h42, 2'd2, 19'h0, 19'h0, 64'h0, 64'h0);
        // 6: LD 0x40 with offset taint on flag 0
        add_load(19'h40, 2'd3, 1'b0, 64'h0123_4567_89AB_CDEF, 8'hFF, 64'h0123_4567_89AB_CDEF);
        vecs[6].addr_t0 = 19'h002; vecs[6].exp_t0 = '1;
        // 7: LH 0x40 with data taint on flag 1
        add_load(19'h40, 2'd1, 1'b0, 64'h1234_5678_9ABC_DEF0, 8'h03, 64'hDEF0);
        vecs[7].rdata_t1 = 64'h100; vecs[7].exp_t1 = 64'h100;
        // 8: LH signed 0x46, sign-bit taint replicated
        add_load(19'h46, 2'd1, 1'b1, 64'h8001_0000_0000_0000, 8'hC0, 64'hFFFF_FFFF_FFFF_8001);
        vecs[8].rdata_t0 = 64'h8000_0000_0000_0000; vecs[8].exp_t0 = 64'hFFFF_FFFF_FFFF_8000;
        // 9: LW unsigned 0x44
        add_load(19'h44, 2'd2, 1'b0, 64'hCAFE_BABE_0000_0000, 8'hF0, 64'hCAFE_BABE);
        vecs[9].rdata_t0 = 64'h00FF_0000_0000_0000; vecs[9].exp_t0 = 64'h00FF_0000;
        // 10: LW signed 0x44
        add_load(19'h44, 2'd2, 1'b1, 64'hCAFE_BABE_0000_0000, 8'hF0, 64'hFFFF_FFFF_CAFE_BABE);
        vecs[10].rdata_t0 = 64'h00FF_0000_0000_0000; vecs[10].exp_t0 = 64'h00FF_0000;
        // 11: SH 0x46, word-address taint and data taint on flag 1; store result taint is 0
        add_store(19'h46, 2'd1, 64'hBEEF, 8'hC0, 64'hBEEF_0000_0000_0000);
        vecs[11].wdata_t1 = 64'h00F0; vecs[11].exp_swdata_t1 = 64'h00F0_0000_0000_0000;
        vecs[11].addr_t1 = 19'h1A8; vecs[11].exp_saddr_t1 = 16'h0035;
        // 12: SD 0x44 misaligned, address taint on flag 1
        add_misalign(19'h44, 2'd3, 19'h0, 19'h10, 64'h0, '1);
        vecs[12].we = 1'b1;
        // 13: LD top word
        add_load(19'h7FFF8, 2'd3, 1'b0, 64'hA5A5_5A5A_0F0F_F0F0, 8'hFF, 64'hA5A5_5A5A_0F0F_F0F0);
        // 14: LH 0x41 misaligned
        add_misalign(19'h41, 2'd1, 19'h0, 19'h0, 64'h0, 64'h0);

        // Reset state
        #1;
        chk("rst_req_ready", 64'(bus.req_ready), 64'd1);
        chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        chk("rst_sram_req", 64'(sram_req), 64'd0);
        chk("rst_sram_be", 64'(sram_be), 64'd0);
        chk("rst_resp_rdata", bus.resp_rdata, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) run_vec(vecs[i], i);

        // Backpressure: response held for 5 cycles
        v = vecs[2];
        @(negedge clk);
        drive_req(v);
        bus.resp_ready = 1'b0;
        sram_rdata = v.rdata; sram_rdata_t0 = v.rdata_t0; sram_rdata_t1 = '0;
        @(posedge clk);
        found = 0;
        for (int c = 1; c <= 8 && found == 0; c++) begin
            @(negedge clk);
            bus.req_valid = 1'b0;
            if (bus.resp_valid) found = c;
        end
        chk("bp_resp_cycle", 64'(found), 64'd3);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("bp_hold%0d_valid", k), 64'(bus.resp_valid), 64'd1);
            chk($sformatf("bp_hold%0d_rdata", k), bus.resp_rdata, 64'hAB);
            chk($sformatf("bp_hold%0d_t0", k), bus.resp_rdata_t0, 64'h1);
            chk($sformatf("bp_hold%0d_ready", k), 64'(bus.req_ready), 64'd0);
        end
        bus.resp_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_valid", 64'(bus.resp_valid), 64'd0);
        chk("bp_release_ready", 64'(bus.req_ready), 64'd1);

        // Reset while the SRAM read is being issued
        drive_req(vecs[6]);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("mid_rst_issue", 64'(sram_req), 64'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_sram_req", 64'(sram_req), 64'd0);
        chk("mid_rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        chk("mid_rst_sram_addr", 64'(sram_addr), 64'd0);
        chk("mid_rst_sram_be", 64'(sram_be), 64'd0);
        chk("mid_rst_req_ready", 64'(bus.req_ready), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (bus.resp_valid || sram_req) bad++;
        end
        chk("mid_rst_no_activity", 64'(bad), 64'd0);

        // Normal operation resumes after reset
        run_vec(vecs[3], 100);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
